// File: rtl/pwm_gen_ch.sv
// pwm_gen_ch: single PWM channel with shadowed period/duty/phase and IDLE/ARM/RUN control
//   axi_clk, axi_rst          clock and synchronous active-high reset
//   en_i                      channel enable (level)
//   period_i, duty_i, phase_i period, high time and manual phase, in clocks
//   ctrl_i                    1: phase from auto_phase_i, 0: phase from phase_i
//   auto_phase_i, auto_end_i  phase controller value and freeze flag
//   pwm_sig_o, pwm_period_o   registered PWM output and period strobe
//   phase_o, state_o          applied phase readback and FSM state
module pwm_gen_ch #(
  parameter int PWM_CNT_WIDTH = 24
) (
  input  logic                     axi_clk,
  input  logic                     axi_rst,
  input  logic                     en_i,
  input  logic [PWM_CNT_WIDTH-1:0] period_i,
  input  logic [PWM_CNT_WIDTH-1:0] duty_i,
  input  logic [PWM_CNT_WIDTH-1:0] phase_i,
  input  logic                     ctrl_i,
  input  logic [PWM_CNT_WIDTH-1:0] auto_phase_i,
  input  logic                     auto_end_i,
  output logic                     pwm_sig_o,
  output logic                     pwm_period_o,
  output logic [PWM_CNT_WIDTH-1:0] phase_o,
  output logic [1:0]               state_o
);
  localparam int W = PWM_CNT_WIDTH;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, per_sh_q, per_sh_d, duty_sh_q, duty_sh_d, ph_sh_q, ph_sh_d;
  logic [W-1:0] per_new, ph_sel, ph_new, pos;
  logic sig_q, sig_d, str_q, str_d, wrap, load, run;
  always_comb begin
    run       = state_q == RUN;
    state_d   = !en_i ? IDLE : (state_q == IDLE ? ARM : RUN);
    wrap      = cnt_q == per_sh_q - W'(1);
    load      = state_q == ARM || (run && wrap);
    per_new   = period_i < W'(2) ? W'(2) : period_i;
    // a frozen auto phase keeps the current shadow, which is still range-checked against the new period
    ph_sel    = ctrl_i ? (auto_end_i ? ph_sh_q : auto_phase_i) : phase_i;
    ph_new    = ph_sel >= per_new ? '0 : ph_sel;
    // ph_sh < per_sh always, so per_sh - ph_sh never underflows and the sum stays below per_sh
    pos       = cnt_q >= ph_sh_q ? cnt_q - ph_sh_q : cnt_q + (per_sh_q - ph_sh_q);
    cnt_d     = (run && en_i && !wrap) ? cnt_q + W'(1) : '0;
    per_sh_d  = load ? per_new : per_sh_q;
    duty_sh_d = load ? duty_i : duty_sh_q;
    ph_sh_d   = load ? ph_new : ph_sh_q;
    sig_d     = run && pos < duty_sh_q;
    str_d     = run && cnt_q == '0;
  end
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      per_sh_q  <= W'(2);
      duty_sh_q <= '0;
      ph_sh_q   <= '0;
      sig_q     <= 1'b0;
      str_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      ph_sh_q   <= ph_sh_d;
      sig_q     <= sig_d;
      str_q     <= str_d;
    end
  end
  assign pwm_sig_o    = sig_q;
  assign pwm_period_o = str_q;
  assign phase_o      = ph_sh_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_pwm_gen_ch.sv
// tb_pwm_gen_ch: directed and random checks of pwm_gen_ch against a modular-arithmetic reference
module tb_pwm_gen_ch;
  localparam int W = 24;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, ctrl = 1'b0, aend = 1'b0;
  logic [W-1:0] period = 10, duty = 3, phase = 0, aph = 0;
  logic sig_o, str_o;
  logic [W-1:0] phase_o;
  logic [1:0] state_o;
  int n_chk = 0, n_fail = 0;
  int m_mode = 0, m_cnt = 0, m_per = 2, m_duty = 0, m_ph = 0;
  bit m_sig = 0, m_str = 0;
  pwm_gen_ch #(.PWM_CNT_WIDTH(W)) dut (
    .axi_clk(clk), .axi_rst(rst), .en_i(en), .period_i(period), .duty_i(duty),
    .phase_i(phase), .ctrl_i(ctrl), .auto_phase_i(aph), .auto_end_i(aend),
    .pwm_sig_o(sig_o), .pwm_period_o(str_o), .phase_o(phase_o), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // reference: mode 0 idle, 1 arm, 2 run; output position is (cnt - phase) mod period
  task automatic tick();
    int per_n, sel;
    bit run, load;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_per = 2; m_duty = 0; m_ph = 0; m_sig = 0; m_str = 0;
    end else begin
      run   = m_mode == 2;
      m_sig = run && (((m_cnt - m_ph + m_per) % m_per) < m_duty);
      m_str = run && m_cnt == 0;
      load  = m_mode == 1 || (run && m_cnt == m_per - 1);
      m_cnt = (run && en) ? (m_cnt + 1) % m_per : 0;
      if (load) begin
        per_n  = period < 2 ? 2 : int'(period);
        sel    = ctrl ? (aend ? m_ph : int'(aph)) : int'(phase);
        m_per  = per_n;
        m_duty = int'(duty);
        m_ph   = sel >= per_n ? 0 : sel;
      end
      m_mode = !en ? 0 : (m_mode == 0 ? 1 : 2);
    end
    #1;
    check("state", 32'(state_o), 32'(m_mode));
    check("sig", 32'(sig_o), 32'(m_sig));
    check("strobe", 32'(str_o), 32'(m_str));
    check("phase", 32'(phase_o), 32'(m_ph));
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wait_cnt(input int c);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_mode == 2 && m_cnt == c) found = 1;
      else tick();
    end
    n_chk++;
    assert (found) else begin
      n_fail++;
      $error("FAIL wait_cnt: observed timeout expected cnt %0d", c);
    end
  endtask
  initial begin
    ticks(2);
    check("rst_state", 32'(state_o), 0);
    check("rst_phase", 32'(phase_o), 0);
    rst = 1'b0;
    en = 1'b1;
    ticks(25);
    phase = 8;
    ticks(12);
    check("phase8", 32'(phase_o), 8);
    ticks(10);
    phase = 15;
    ticks(12);
    check("phase15", 32'(phase_o), 0);
    phase = 0;
    duty = 0;
    ticks(22);
    duty = 12;
    ticks(22);
    period = 1;
    duty = 1;
    ticks(10);
    period = 10;
    duty = 3;
    ticks(15);
    wait_cnt(4);
    duty = 6;
    ticks(25);
    ctrl = 1'b1;
    aph = 5;
    ticks(12);
    check("auto5", 32'(phase_o), 5);
    aph = 7;
    aend = 1'b1;
    ticks(12);
    check("auto_hold", 32'(phase_o), 5);
    ctrl = 1'b0;
    aend = 1'b0;
    phase = 2;
    ticks(12);
    check("manual2", 32'(phase_o), 2);
    wait_cnt(6);
    rst = 1'b1;
    tick();
    check("rst_mid_sig", 32'(sig_o), 0);
    check("rst_mid_state", 32'(state_o), 0);
    rst = 1'b0;
    ticks(15);
    wait_cnt(5);
    en = 1'b0;
    ticks(5);
    en = 1'b1;
    ticks(5);
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 149) == 0;
      en  = $urandom_range(0, 29) != 0;
      if ($urandom_range(0, 9) == 0) begin
        period = W'($urandom_range(0, 20));
        duty   = W'($urandom_range(0, 24));
        phase  = W'($urandom_range(0, 24));
        aph    = W'($urandom_range(0, 24));
        ctrl   = 1'($urandom_range(0, 1));
        aend   = 1'($urandom_range(0, 1));
      end
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
